// File: rtl/ring_buffer_write_arbiter.sv
// Round-robin arbiter that lets one of several producers write bursts of up to
// MaxBurst words into a shared downstream FIFO, with one idle cycle between grants.
module ring_buffer_write_arbiter #(
    parameter int WordLengthBits = 8,
    parameter int NumRequesters  = 4,
    parameter int MaxBurst       = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NumRequesters-1:0]                req_valid,
    input  logic [NumRequesters*WordLengthBits-1:0] req_data,
    output logic [NumRequesters-1:0]                req_ready,
    input  logic                                    buffer_100p_full,
    output logic                                    put,
    output logic [WordLengthBits-1:0]               data_in,
    output logic                                    grant_valid,
    output logic [$clog2(NumRequesters)-1:0]        grant_id
);

    localparam int IW = $clog2(NumRequesters);
    localparam int CW = $clog2(MaxBurst + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NumRequesters - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MaxBurst - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    // gid_q is the granted index in GRANT and doubles as last_id in IDLE.
    logic [IW-1:0] gid_q, gid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] winner;
    logic          any_valid;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        winner    = gid_q;
        any_valid = 1'b0;
        for (int k = 1; k <= NumRequesters; k++) begin
            int idx;
            idx = (int'(gid_q) + k) % NumRequesters;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = IW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        put       = 1'b0;
        data_in   = '0;
        if (state_q == GRANT) begin
            req_ready[gid_q] = !buffer_100p_full;
            put              = req_valid[gid_q] && !buffer_100p_full;
            data_in          = req_data[int'(gid_q)*WordLengthBits +: WordLengthBits];
        end
    end

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    gid_d   = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // A dropped valid releases the grant even while the FIFO is full.
                if (!req_valid[gid_q] || (put && cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (put) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gid_q   <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_id    = gid_q;

endmodule

// File: tb/tb_ring_buffer_write_arbiter.sv
// Bench for ring_buffer_write_arbiter: directed bursts with hand-computed
// (id, word, cycle) expectations, async reset, and a random ordering run.
module tb_ring_buffer_write_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int EW = 2 + W + 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           full;
    logic           put;
    logic [W-1:0]   data_in;
    logic           grant_valid;
    logic [1:0]     grant_id;

    ring_buffer_write_arbiter #(
        .WordLengthBits(W),
        .NumRequesters (N),
        .MaxBurst      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .buffer_100p_full(full),
        .put             (put),
        .data_in         (data_in),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit rnd_mode = 0;
    bit rnd_fill = 0;
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  src_q[N][$];
    logic [N-1:0]  acc_mask = '0;
    logic [5:0]    next_seq[N];
    logic [5:0]    gen_seq[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic present();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (src_q[i].size() > 0);
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input int data, input int rel);
        exp_q.push_back({2'(id), 8'(data), 16'(rel)});
    endtask

    // Requester model: retire accepted words, optionally refill, re-present.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++)
            if (acc_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        acc_mask = '0;
        if (rnd_fill)
            for (int i = 0; i < N; i++)
                if (src_q[i].size() < 2 && $urandom_range(0, 2) == 0) begin
                    src_q[i].push_back({2'(i), gen_seq[i]});
                    gen_seq[i] = gen_seq[i] + 6'd1;
                end
        present();
    end

    // Monitor: pops the expected queue whenever the DUT writes the FIFO.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [1:0] id;
        acc_mask = req_valid & req_ready;
        if (!rst) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (full) chk("put_while_full", 32'(put), 32'd0);
            if (put) begin
                if (rnd_mode) begin
                    id = data_in[7:6];
                    chk("rnd_order", 32'(data_in[5:0]), 32'(next_seq[id]));
                    chk("rnd_grant_id", 32'(grant_id), 32'(id));
                    next_seq[id] = next_seq[id] + 6'd1;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_put: id %0d data %0h cycle %0d, expected none",
                             grant_id, data_in, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({grant_id, data_in, 16'(cyc - t0)} !== e) begin
                        errors++;
                        $display("FAIL put: id %0d data %0h cycle %0d, expected id %0d data %0h cycle %0d",
                                 grant_id, data_in, cyc - t0, e[EW-1 -: 2], e[15+W -: W], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst  = 1'b1;
        full = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        present();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || grant_valid) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({name, "_timeout"}, 32'(n < 100), 32'd1);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        full      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        #3;
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_put", 32'(put), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);

        // Single requester 2: four words, one bubble, two more.
        do_reset();
        for (int j = 0; j < 6; j++) src_q[2].push_back(8'(8'h10 + j));
        push_exp(2, 'h10, 1); push_exp(2, 'h11, 2); push_exp(2, 'h12, 3);
        push_exp(2, 'h13, 4); push_exp(2, 'h14, 6); push_exp(2, 'h15, 7);
        t0 = cyc;
        present();
        wait_done("single");

        // All four valid: bursts of four with one idle cycle, then fifth words.
        do_reset();
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 5; j++) src_q[k].push_back(8'(k*16 + j));
            for (int j = 0; j < 4; j++) push_exp(k, k*16 + j, 1 + 5*k + j);
        end
        for (int k = 0; k < N; k++) push_exp(k, k*16 + 4, 21 + 3*k);
        t0 = cyc;
        present();
        wait_done("round_robin");

        // Backpressure for three cycles after two words.
        do_reset();
        for (int j = 0; j < 4; j++) src_q[0].push_back(8'(8'h50 + j));
        push_exp(0, 'h50, 1); push_exp(0, 'h51, 2); push_exp(0, 'h52, 6); push_exp(0, 'h53, 7);
        t0 = cyc;
        present();
        repeat (3) begin @(posedge clk); #2; end
        full = 1'b1;
        repeat (3) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_put", 32'(put), 32'd0);
            chk("bp_grant_valid", 32'(grant_valid), 32'd1);
            chk("bp_grant_id", 32'(grant_id), 32'd0);
            @(posedge clk);
            #2;
        end
        full = 1'b0;
        wait_done("backpressure");

        // Requester 1 has one word; grant then moves to 3 (0 and 2 idle).
        do_reset();
        src_q[1].push_back(8'hA1);
        src_q[3].push_back(8'hC0);
        src_q[3].push_back(8'hC1);
        push_exp(1, 'hA1, 1); push_exp(3, 'hC0, 4); push_exp(3, 'hC1, 5);
        t0 = cyc;
        present();
        wait_done("early_release");

        // Asynchronous reset in the middle of a burst.
        do_reset();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 4; j++) src_q[k].push_back(8'(8'h60 + k*4 + j));
        push_exp(0, 'h60, 1); push_exp(0, 'h61, 2);
        t0 = cyc;
        present();
        repeat (3) begin @(posedge clk); #2; end
        #1;
        rst = 1'b1;
        #1;
        chk("arst_grant_valid", 32'(grant_valid), 32'd0);
        chk("arst_put", 32'(put), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        chk("arst_grant_id", 32'(grant_id), 32'd3);
        chk("arst_words_before", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        present();
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            src_q[k].push_back(8'(8'h70 + k));
            push_exp(k, 'h70 + k, 1 + 3*k);
        end
        t0 = cyc;
        present();
        wait_done("after_reset");

        // Random valid/full traffic: per-requester order and invariants.
        do_reset();
        for (int i = 0; i < N; i++) begin
            next_seq[i] = '0;
            gen_seq[i]  = '0;
        end
        rnd_mode = 1'b1;
        rnd_fill = 1'b1;
        repeat (10000) begin
            @(posedge clk);
            #2;
            full = ($urandom_range(0, 3) == 0);
        end
        rnd_fill = 1'b0;
        full = 1'b0;
        begin
            int n = 0;
            while ((req_valid != '0 || grant_valid) && n < 200) begin
                @(posedge clk);
                #2;
                n++;
            end
            chk("rnd_drain_timeout", 32'(n < 200), 32'd1);
        end
        for (int i = 0; i < N; i++) chk("rnd_count", 32'(next_seq[i]), 32'(gen_seq[i]));
        rnd_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
